// File: rtl/c64_bus_slave_if.sv
// rtl/c64_bus_slave_if.sv - expansion-port bus and register-file request bundle for c64_bus_slave
interface c64_bus_slave_if #(
   parameter int IO_ADDR_BITS = 5
);
   logic                    phi2_lock;
   logic                    half_p1;
   logic                    full_m2;
   logic                    full_p1;
   logic [15:0]             addr_in;
   logic [7:0]              data_in;
   logic                    rw_in;
   logic                    io1_n;
   logic                    io2_n;
   logic [7:0]              reg_rdata;
   logic                    reg_rd;
   logic                    reg_wr;
   logic [IO_ADDR_BITS-1:0] reg_addr;
   logic [7:0]              reg_wdata;
   logic                    reg_io1;
   logic [7:0]              data_out;
   logic                    data_oe;

   modport slave (
      input  phi2_lock, half_p1, full_m2, full_p1, addr_in, data_in, rw_in,
             io1_n, io2_n, reg_rdata,
      output reg_rd, reg_wr, reg_addr, reg_wdata, reg_io1, data_out, data_oe
   );

   modport master (
      output phi2_lock, half_p1, full_m2, full_p1, addr_in, data_in, rw_in,
             io1_n, io2_n, reg_rdata,
      input  reg_rd, reg_wr, reg_addr, reg_wdata, reg_io1, data_out, data_oe
   );
endinterface

// File: rtl/c64_bus_slave.sv
// rtl/c64_bus_slave.sv - IO2 bus slave issuing one register request per phi2 cycle; C64_BUS_SLAVE_IO1_EN adds IO1
module c64_bus_slave #(
   parameter int IO_ADDR_BITS = 5,
   parameter int OE_HOLD      = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   c64_bus_slave_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, RD_DRIVE, WR_WAIT, WR_REQ} state_t;
   localparam logic [1:0] OE_HOLD_C = 2'(OE_HOLD);

   state_t                  state_q, state_d;
   logic [IO_ADDR_BITS-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]              reg_wdata_q, reg_wdata_d;
   logic [7:0]              data_out_q, data_out_d;
   logic                    reg_io1_q, reg_io1_d;
   logic                    data_oe_q, data_oe_d;
   logic [1:0]              hold_cnt_q, hold_cnt_d;
   logic                    sel_io1, start, drive_done;
   logic                    unused_bus;

   assign unused_bus = ^{bus.io1_n, bus.addr_in[15:IO_ADDR_BITS]};

   always_comb begin
`ifdef C64_BUS_SLAVE_IO1_EN
      sel_io1 = ~bus.io1_n & bus.io2_n;
`else
      sel_io1 = 1'b0;
`endif
      // full_p1 wins a collision with half_p1 from a degenerate divider
      start = bus.phi2_lock & bus.half_p1 & ~bus.full_p1 & (~bus.io2_n | sel_io1);
      drive_done = (hold_cnt_q == 2'd1) ||
                   (hold_cnt_q == 2'd0 && bus.full_p1 && OE_HOLD_C == 2'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         reg_addr_q  <= '0;
         reg_wdata_q <= 8'h00;
         data_out_q  <= 8'h00;
         reg_io1_q   <= 1'b0;
         data_oe_q   <= 1'b0;
         hold_cnt_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         data_out_q  <= data_out_d;
         reg_io1_q   <= reg_io1_d;
         data_oe_q   <= data_oe_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = bus.rw_in ? RD_REQ : WR_WAIT;
         RD_REQ:   state_d = RD_CAP;
         RD_CAP:   state_d = RD_DRIVE;
         RD_DRIVE: if (drive_done) state_d = IDLE;
         WR_WAIT:  if (bus.full_m2) state_d = WR_REQ;
         WR_REQ:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      // an issued write strobe completes; everything else aborts on lock loss
      if (!bus.phi2_lock && state_q != WR_REQ) state_d = IDLE;
   end

   always_comb begin
      reg_addr_d  = reg_addr_q;
      reg_io1_d   = reg_io1_q;
      reg_wdata_d = reg_wdata_q;
      data_out_d  = data_out_q;
      hold_cnt_d  = 2'd0;
      if (state_q == IDLE && start) begin
         reg_addr_d = bus.addr_in[IO_ADDR_BITS-1:0];
         reg_io1_d  = sel_io1;
      end
      if (state_q == WR_WAIT && bus.full_m2 && bus.phi2_lock) reg_wdata_d = bus.data_in;
      if (state_q == RD_CAP && bus.phi2_lock) data_out_d = bus.reg_rdata;
      if (state_q == RD_DRIVE && bus.phi2_lock && !drive_done) begin
         if (hold_cnt_q != 2'd0)  hold_cnt_d = hold_cnt_q - 2'd1;
         else if (bus.full_p1)    hold_cnt_d = OE_HOLD_C;
      end
      data_oe_d  = (state_d == RD_DRIVE);
      bus.reg_rd = (state_q == RD_REQ);
      bus.reg_wr = (state_q == WR_REQ);
   end

   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_io1   = reg_io1_q;
   assign bus.data_out  = data_out_q;
   assign bus.data_oe   = data_oe_q;
endmodule
